// File: rtl/spi_codec_configurator_if.sv
// Host command/response port of the SPI codec configurator.
// master = host side, slave = configurator side.
interface spi_codec_configurator_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DW         = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_rw;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DW-1:0]         cmd_wdata;
    logic                  rsp_valid;
    logic [DW-1:0]         rsp_rdata;

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/spi_codec_configurator.sv
// SPI control-port master for ADAU1761-class codecs: SPI-mode entry, table-driven init,
// then single read/write commands with read data returned on the response port.
module spi_codec_configurator #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_BYTES   = 1,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned DUMMY_FRAMES = 3,
    parameter int unsigned INIT_LEN     = 18,
    parameter int unsigned CS_GAP       = 4,
    localparam int unsigned DW          = 8 * DATA_BYTES
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  sclk,
    output logic                  cs,
    output logic                  sdo,
    input  logic                  sdi,
    spi_codec_configurator_if.slave bus,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,
    output logic [7:0]            rom_index,
    input  logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DW-1:0]         rom_data
);
    localparam int unsigned FL  = 8 + ADDR_WIDTH + DW;
    localparam int unsigned BCW = $clog2(FL + 1);
    localparam int unsigned DVW = $clog2(CLK_DIV);
    localparam int unsigned GCW = (CS_GAP < 2) ? 1 : $clog2(CS_GAP);
    localparam int unsigned DCW = (DUMMY_FRAMES < 1) ? 1 : $clog2(DUMMY_FRAMES + 1);

    localparam logic [BCW-1:0] BIT_LAST   = BCW'(FL - 1);
    localparam logic [DVW-1:0] DIV_LAST   = DVW'(CLK_DIV - 1);
    localparam logic [GCW-1:0] GAP_LAST   = GCW'(CS_GAP - 1);
    localparam logic [DCW-1:0] DUMMY_LAST = DCW'(DUMMY_FRAMES);
    localparam logic [7:0]     IDX_LAST   = 8'(INIT_LEN - 1);

    typedef enum logic [2:0] {StIdle, StDummy, StFetch, StShift, StGap} state_e;

    state_e          state_q, state_d;
    logic [FL-1:0]   sh_q, sh_d;
    logic [DW-1:0]   rx_q, rx_d;
    logic [BCW-1:0]  bit_q, bit_d;
    logic [DVW-1:0]  div_q, div_d;
    logic [GCW-1:0]  gap_q, gap_d;
    logic [DCW-1:0]  dummy_q, dummy_d;
    logic            host_q, host_d;
    logic            read_q, read_d;
    logic            tbl_q, tbl_d;
    logic            sclk_q, sclk_d;
    logic            cs_q, cs_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            init_busy_q, init_busy_d;
    logic            init_done_q, init_done_d;
    logic [7:0]      rom_index_q, rom_index_d;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        rx_d        = rx_q;
        bit_d       = bit_q;
        div_d       = div_q;
        gap_d       = gap_q;
        dummy_d     = dummy_q;
        host_d      = host_q;
        read_d      = read_q;
        tbl_d       = tbl_q;
        sclk_d      = sclk_q;
        cs_d        = cs_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        init_busy_d = init_busy_q;
        init_done_d = init_done_q;
        rom_index_d = rom_index_q;

        unique case (state_q)
            StIdle: begin
                if (!cmd_ready_q) begin
                    cmd_ready_d = 1'b1;
                end else if (init_start) begin
                    state_d     = StDummy;
                    init_busy_d = 1'b1;
                    init_done_d = 1'b0;
                    cmd_ready_d = 1'b0;
                    dummy_d     = '0;
                    tbl_d       = 1'b0;
                    rom_index_d = 8'h00;
                end else if (bus.cmd_valid) begin
                    sh_d        = {7'b0, bus.cmd_rw, bus.cmd_addr,
                                   bus.cmd_rw ? {DW{1'b0}} : bus.cmd_wdata};
                    host_d      = 1'b1;
                    read_d      = bus.cmd_rw;
                    cmd_ready_d = 1'b0;
                    state_d     = StShift;
                end
            end
            StDummy: begin
                if (dummy_q == DUMMY_LAST) begin
                    state_d     = StFetch;
                    tbl_d       = 1'b1;
                    rom_index_d = 8'h00;
                end else begin
                    sh_d    = '0;
                    host_d  = 1'b0;
                    read_d  = 1'b0;
                    dummy_d = dummy_q + 1'b1;
                    state_d = StShift;
                end
            end
            StFetch: begin
                sh_d    = {8'h00, rom_addr, rom_data};
                host_d  = 1'b0;
                read_d  = 1'b0;
                state_d = StShift;
            end
            StShift: begin
                // First cycle in SHIFT only drops cs; the bit clock starts from there.
                if (cs_q) begin
                    cs_d   = 1'b0;
                    sclk_d = 1'b0;
                    div_d  = '0;
                    bit_d  = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[DW-2:0], sdi};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            cs_d    = 1'b1;
                            gap_d   = '0;
                            state_d = StGap;
                            if (host_q) begin
                                rsp_valid_d = 1'b1;
                                rsp_rdata_d = read_q ? rx_q : '0;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                            sh_d  = {sh_q[FL-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GAP_LAST) begin
                    if (host_q) begin
                        state_d     = StIdle;
                        cmd_ready_d = 1'b1;
                    end else if (!tbl_q) begin
                        state_d = StDummy;
                    end else if (rom_index_q == IDX_LAST) begin
                        state_d     = StIdle;
                        init_busy_d = 1'b0;
                        init_done_d = 1'b1;
                        rom_index_d = 8'h00;
                        cmd_ready_d = 1'b1;
                    end else begin
                        rom_index_d = rom_index_q + 8'h01;
                        state_d     = StFetch;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            sh_q        <= '0;
            rx_q        <= '0;
            bit_q       <= '0;
            div_q       <= '0;
            gap_q       <= '0;
            dummy_q     <= '0;
            host_q      <= 1'b0;
            read_q      <= 1'b0;
            tbl_q       <= 1'b0;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b0;
            rom_index_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            rx_q        <= rx_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            dummy_q     <= dummy_d;
            host_q      <= host_d;
            read_q      <= read_d;
            tbl_q       <= tbl_d;
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            init_busy_q <= init_busy_d;
            init_done_q <= init_done_d;
            rom_index_q <= rom_index_d;
        end
    end

    assign sclk          = sclk_q;
    assign cs            = cs_q;
    // sdo is forced low whenever the frame is not active.
    assign sdo           = ~cs_q & sh_q[FL-1];
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign init_busy     = init_busy_q;
    assign init_done     = init_done_q;
    assign rom_index     = rom_index_q;
endmodule

// File: tb/tb_spi_codec_configurator.sv
// Directed bench: dut0 = default widths with a 2-entry table, dut1 = 16-bit data, CLK_DIV=2.
module tb_spi_codec_configurator;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // ---------------- dut0 ----------------
    logic        sclk0, cs0, sdo0, sdi0, init_start0, init_busy0, init_done0;
    logic [7:0]  rom_index0;
    logic [15:0] rom_addr0;
    logic [7:0]  rom_data0;
    logic [31:0] miso0 = '0;

    spi_codec_configurator_if #(.ADDR_WIDTH(16), .DW(8)) if0 ();

    spi_codec_configurator #(
        .ADDR_WIDTH(16), .DATA_BYTES(1), .CLK_DIV(4), .DUMMY_FRAMES(3), .INIT_LEN(2), .CS_GAP(4)
    ) dut0 (
        .clk(clk), .resetn(resetn), .sclk(sclk0), .cs(cs0), .sdo(sdo0), .sdi(sdi0), .bus(if0),
        .init_start(init_start0), .init_busy(init_busy0), .init_done(init_done0),
        .rom_index(rom_index0), .rom_addr(rom_addr0), .rom_data(rom_data0)
    );

    assign rom_addr0 = (rom_index0 == 8'd0) ? 16'h4000 : 16'h40FA;
    assign rom_data0 = (rom_index0 == 8'd0) ? 8'h01 : 8'h03;

    // ---------------- dut1 ----------------
    logic        sclk1, cs1, sdo1, sdi1, init_busy1, init_done1;
    logic [7:0]  rom_index1;
    logic [39:0] miso1 = '0;

    spi_codec_configurator_if #(.ADDR_WIDTH(16), .DW(16)) if1 ();

    spi_codec_configurator #(
        .ADDR_WIDTH(16), .DATA_BYTES(2), .CLK_DIV(2), .DUMMY_FRAMES(3), .INIT_LEN(2), .CS_GAP(4)
    ) dut1 (
        .clk(clk), .resetn(resetn), .sclk(sclk1), .cs(cs1), .sdo(sdo1), .sdi(sdi1), .bus(if1),
        .init_start(1'b0), .init_busy(init_busy1), .init_done(init_done1),
        .rom_index(rom_index1), .rom_addr(16'h0000), .rom_data(16'h0000)
    );

    // ---------------- codec models / monitors ----------------
    logic [63:0] mosi0 = '0;
    int          bits0 = 0;
    logic [63:0] mosi1 = '0;
    int          bits1 = 0;

    assign sdi0 = (!cs0 && bits0 < 32) ? miso0[31 - bits0] : 1'b0;
    assign sdi1 = (!cs1 && bits1 < 40) ? miso1[39 - bits1] : 1'b0;

    always @(posedge sclk0 or negedge cs0) begin
        if (sclk0) begin
            mosi0 = {mosi0[62:0], sdo0};
            bits0 = bits0 + 1;
        end else begin
            mosi0 = '0;
            bits0 = 0;
        end
    end

    always @(posedge sclk1 or negedge cs1) begin
        if (sclk1) begin
            mosi1 = {mosi1[62:0], sdo1};
            bits1 = bits1 + 1;
        end else begin
            mosi1 = '0;
            bits1 = 0;
        end
    end

    logic [63:0] frames0[$];
    int          lens0[$];
    int          low0 = 0, high0 = 0, mingap0 = 1000, rsp_cnt0 = 0;
    logic [7:0]  rsp_last0 = '0;
    logic        prev_cs0 = 1'b1;

    always @(negedge clk) begin
        if (!cs0) begin
            if (prev_cs0 && frames0.size() > 0 && high0 < mingap0) mingap0 = high0;
            low0 = low0 + 1;
        end else begin
            if (!prev_cs0) begin
                frames0.push_back(mosi0);
                lens0.push_back(low0);
                low0  = 0;
                high0 = 0;
            end
            high0 = high0 + 1;
        end
        prev_cs0 = cs0;
        if (if0.rsp_valid) begin
            rsp_cnt0  = rsp_cnt0 + 1;
            rsp_last0 = if0.rsp_rdata;
        end
    end

    logic [63:0] frames1[$];
    int          lens1[$];
    int          low1 = 0, rsp_cnt1 = 0;
    logic [15:0] rsp_last1 = '0;
    logic        prev_cs1 = 1'b1;

    always @(negedge clk) begin
        if (!cs1) begin
            low1 = low1 + 1;
        end else if (!prev_cs1) begin
            frames1.push_back(mosi1);
            lens1.push_back(low1);
            low1 = 0;
        end
        prev_cs1 = cs1;
        if (if1.rsp_valid) begin
            rsp_cnt1  = rsp_cnt1 + 1;
            rsp_last1 = if1.rsp_rdata;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (cs0 !== 1'b1) begin tests_failed++; $display("FAIL reset_cs: got %b want 1", cs0); end
        tests_run++; if (sclk0 !== 1'b0) begin tests_failed++; $display("FAIL reset_sclk: got %b want 0", sclk0); end
        tests_run++; if (sdo0 !== 1'b0) begin tests_failed++; $display("FAIL reset_sdo: got %b want 0", sdo0); end
        tests_run++; if (if0.cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b want 0", if0.cmd_ready); end
        tests_run++; if (if0.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", if0.rsp_valid); end
        tests_run++; if (if0.rsp_rdata !== 8'h00) begin tests_failed++; $display("FAIL reset_rsp_rdata: got %h want 00", if0.rsp_rdata); end
        tests_run++; if (init_busy0 !== 1'b0) begin tests_failed++; $display("FAIL reset_init_busy: got %b want 0", init_busy0); end
        tests_run++; if (init_done0 !== 1'b0) begin tests_failed++; $display("FAIL reset_init_done: got %b want 0", init_done0); end
        tests_run++; if (rom_index0 !== 8'h00) begin tests_failed++; $display("FAIL reset_rom_index: got %h want 00", rom_index0); end
        tests_run++; if ({cs1, sclk1, init_busy1, init_done1, rom_index1} !== 12'h800) begin
            tests_failed++; $display("FAIL reset_dut1: got %h want 800", {cs1, sclk1, init_busy1, init_done1, rom_index1}); end
        resetn = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (if0.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL release_cmd_ready0: got %b want 1", if0.cmd_ready); end
        tests_run++; if (if1.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL release_cmd_ready1: got %b want 1", if1.cmd_ready); end
    endtask

    // init_start and a write command arrive together; init must run first.
    task automatic test_init_priority();
        bit ok = 0;
        bit leaked = 0;
        @(negedge clk);
        init_start0   = 1'b1;
        if0.cmd_valid = 1'b1;
        if0.cmd_rw    = 1'b0;
        if0.cmd_addr  = 16'h4023;
        if0.cmd_wdata = 8'hF7;
        @(posedge clk); #1;
        init_start0 = 1'b0;
        tests_run++; if (init_busy0 !== 1'b1) begin tests_failed++; $display("FAIL init_busy_set: got %b want 1", init_busy0); end
        tests_run++; if (if0.cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL init_cmd_ready: got %b want 0", if0.cmd_ready); end
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk); #1;
            if (init_done0) begin ok = 1; break; end
            if (if0.cmd_ready) leaked = 1;
        end
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL init_timeout: init_done got 0 want 1"); end
        tests_run++; if (leaked !== 1'b0) begin tests_failed++; $display("FAIL init_cmd_leak: cmd_ready during init got 1 want 0"); end
        tests_run++; if (frames0.size() != 5) begin tests_failed++; $display("FAIL init_frame_count: got %0d want 5", frames0.size()); end
        if (frames0.size() >= 5) begin
            for (int i = 0; i < 3; i++) begin
                tests_run++; if (frames0[i] !== 64'h0) begin tests_failed++; $display("FAIL dummy_frame%0d: got %h want 0", i, frames0[i]); end
                tests_run++; if (lens0[i] != 256) begin tests_failed++; $display("FAIL dummy_len%0d: got %0d want 256", i, lens0[i]); end
            end
            tests_run++; if (frames0[3] !== 64'h00400001) begin tests_failed++; $display("FAIL table_frame0: got %h want 00400001", frames0[3]); end
            tests_run++; if (frames0[4] !== 64'h0040FA03) begin tests_failed++; $display("FAIL table_frame1: got %h want 0040fa03", frames0[4]); end
            tests_run++; if (lens0[4] != 256) begin tests_failed++; $display("FAIL table_len1: got %0d want 256", lens0[4]); end
        end
        tests_run++; if (mingap0 < 4) begin tests_failed++; $display("FAIL init_cs_gap: got %0d want >=4", mingap0); end
        tests_run++; if (rsp_cnt0 != 0) begin tests_failed++; $display("FAIL init_rsp_valid: got %0d pulses want 0", rsp_cnt0); end
        tests_run++; if (init_busy0 !== 1'b0) begin tests_failed++; $display("FAIL init_busy_clear: got %b want 0", init_busy0); end
        tests_run++; if (rom_index0 !== 8'h00) begin tests_failed++; $display("FAIL init_rom_index: got %h want 00", rom_index0); end
    endtask

    // The write held since init is accepted on the next edge.
    task automatic test_write();
        bit ok = 0;
        int cycles = 0;
        @(posedge clk); #1;
        if0.cmd_valid = 1'b0;
        tests_run++; if (if0.cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL write_accept: cmd_ready got %b want 0", if0.cmd_ready); end
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (rsp_cnt0 == 1) begin ok = 1; break; end
        end
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL write_timeout: rsp_valid got 0 want 1"); end
        tests_run++; if (frames0.size() != 6) begin tests_failed++; $display("FAIL write_frame_count: got %0d want 6", frames0.size()); end
        if (frames0.size() >= 6) begin
            tests_run++; if (frames0[5] !== 64'h004023F7) begin tests_failed++; $display("FAIL write_frame: got %h want 004023f7", frames0[5]); end
            tests_run++; if (lens0[5] != 256) begin tests_failed++; $display("FAIL write_len: got %0d want 256", lens0[5]); end
        end
        tests_run++; if (rsp_last0 !== 8'h00) begin tests_failed++; $display("FAIL write_rdata: got %h want 00", rsp_last0); end
        while (!if0.cmd_ready && cycles < 20) begin
            @(negedge clk); #1;
            cycles++;
        end
        tests_run++; if (cycles != 4) begin tests_failed++; $display("FAIL write_ready_gap: got %0d want 4", cycles); end
        tests_run++; if (rsp_cnt0 != 1) begin tests_failed++; $display("FAIL write_rsp_pulses: got %0d want 1", rsp_cnt0); end
    endtask

    task automatic test_read();
        bit ok = 0;
        int base;
        @(negedge clk);
        miso0         = 32'h000000A5;
        if0.cmd_valid = 1'b1;
        if0.cmd_rw    = 1'b1;
        if0.cmd_addr  = 16'h4000;
        if0.cmd_wdata = 8'h33;
        @(posedge clk); #1;
        if0.cmd_valid = 1'b0;
        base = rsp_cnt0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (rsp_cnt0 == base + 1) begin ok = 1; break; end
        end
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL read_timeout: rsp_valid got 0 want 1"); end
        tests_run++; if (frames0[frames0.size()-1] !== 64'h01400000) begin
            tests_failed++; $display("FAIL read_frame: got %h want 01400000", frames0[frames0.size()-1]); end
        tests_run++; if (lens0[lens0.size()-1] != 256) begin tests_failed++; $display("FAIL read_len: got %0d want 256", lens0[lens0.size()-1]); end
        tests_run++; if (rsp_last0 !== 8'hA5) begin tests_failed++; $display("FAIL read_rdata: got %h want a5", rsp_last0); end
    endtask

    task automatic test_wide_read();
        bit ok = 0;
        @(negedge clk);
        miso1         = 40'h000000BEEF;
        if1.cmd_valid = 1'b1;
        if1.cmd_rw    = 1'b1;
        if1.cmd_addr  = 16'h4002;
        if1.cmd_wdata = 16'h1234;
        @(posedge clk); #1;
        if1.cmd_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (rsp_cnt1 == 1) begin ok = 1; break; end
        end
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL wide_timeout: rsp_valid got 0 want 1"); end
        tests_run++; if (frames1.size() != 1) begin tests_failed++; $display("FAIL wide_frame_count: got %0d want 1", frames1.size()); end
        if (frames1.size() >= 1) begin
            tests_run++; if (frames1[0] !== 64'h0140020000) begin tests_failed++; $display("FAIL wide_frame: got %h want 0140020000", frames1[0]); end
            tests_run++; if (lens1[0] != 160) begin tests_failed++; $display("FAIL wide_len: got %0d want 160", lens1[0]); end
        end
        tests_run++; if (rsp_last1 !== 16'hBEEF) begin tests_failed++; $display("FAIL wide_rdata: got %h want beef", rsp_last1); end
    endtask

    task automatic test_reset_midframe();
        bit ok = 0;
        int base;
        @(negedge clk);
        if0.cmd_valid = 1'b1;
        if0.cmd_rw    = 1'b0;
        if0.cmd_addr  = 16'h4023;
        if0.cmd_wdata = 8'hF7;
        @(posedge clk); #1;
        if0.cmd_valid = 1'b0;
        base = rsp_cnt0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (bits0 == 10) begin ok = 1; break; end
        end
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL mid_timeout: bit 10 got 0 want 1"); end
        tests_run++; if ({cs0, sclk0} !== 2'b01) begin tests_failed++; $display("FAIL mid_pre: cs,sclk got %b want 01", {cs0, sclk0}); end
        resetn = 1'b0;
        #1;
        tests_run++; if (cs0 !== 1'b1) begin tests_failed++; $display("FAIL mid_cs: got %b want 1", cs0); end
        tests_run++; if (sclk0 !== 1'b0) begin tests_failed++; $display("FAIL mid_sclk: got %b want 0", sclk0); end
        tests_run++; if (init_done0 !== 1'b0) begin tests_failed++; $display("FAIL mid_init_done: got %b want 0", init_done0); end
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (rsp_cnt0 != base) begin tests_failed++; $display("FAIL mid_rsp: got %0d want %0d", rsp_cnt0, base); end
        tests_run++; if (if0.cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_ready_low: got %b want 0", if0.cmd_ready); end
        resetn = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (if0.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_ready_release: got %b want 1", if0.cmd_ready); end
    endtask

    initial begin
        init_start0   = 1'b0;
        if0.cmd_valid = 1'b0;
        if0.cmd_rw    = 1'b0;
        if0.cmd_addr  = '0;
        if0.cmd_wdata = '0;
        if1.cmd_valid = 1'b0;
        if1.cmd_rw    = 1'b0;
        if1.cmd_addr  = '0;
        if1.cmd_wdata = '0;
        test_reset();
        test_init_priority();
        test_write();
        test_read();
        test_wide_read();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
